// File: rtl/simple_alu_if.sv
// Operand/result bundle between the register-file read ports and the ALU.
interface simple_alu_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 3
);
    logic [OP_WIDTH-1:0]   op;
    logic [DATA_WIDTH-1:0] in1;
    logic [DATA_WIDTH-1:0] in2;
    logic [DATA_WIDTH-1:0] out_alu;
    logic                  zero;
    logic                  ovf;

    modport master (
        output op, in1, in2,
        input  out_alu, zero, ovf
    );

    modport slave (
        input  op, in1, in2,
        output out_alu, zero, ovf
    );
endinterface

// File: rtl/simple_alu.sv
// Signed integer ALU: eight ops selected by a 3-bit opcode.
// Result, zero and overflow flags are registered one clock after sampling.
module simple_alu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 3
) (
    input  logic         clk,
    input  logic         rst,
    simple_alu_if.slave  bus
);
    localparam int unsigned HW  = DATA_WIDTH / 2;
    localparam int unsigned MSB = DATA_WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_EQ  = 3'b010,
        OP_GT  = 3'b011,
        OP_MUL = 3'b100,
        OP_NOT = 3'b101,
        OP_AND = 3'b110,
        OP_OR  = 3'b111
    } alu_op_e;

    alu_op_e                       w_op;
    logic signed [DATA_WIDTH-1:0]  w_a;
    logic signed [DATA_WIDTH-1:0]  w_b;
    logic signed [DATA_WIDTH-1:0]  w_sum;
    logic signed [DATA_WIDTH-1:0]  w_diff;
    logic signed [DATA_WIDTH-1:0]  w_prod;
    logic signed [DATA_WIDTH-1:0]  w_a_ext;
    logic signed [DATA_WIDTH-1:0]  w_b_ext;
    logic        [DATA_WIDTH-1:0]  w_res;
    logic                          w_ovf;

    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_zero;
    logic                  r_ovf;

    // Only the low three opcode bits select an operation.
    assign w_op = alu_op_e'(bus.op[2:0]);
    assign w_a  = bus.in1;
    assign w_b  = bus.in2;

    assign w_sum  = w_a + w_b;
    assign w_diff = w_a - w_b;

    // Half-width signed operands, sign-extended so the full product fits exactly.
    assign w_a_ext = {{HW{w_a[HW-1]}}, w_a[HW-1:0]};
    assign w_b_ext = {{HW{w_b[HW-1]}}, w_b[HW-1:0]};
    assign w_prod  = w_a_ext * w_b_ext;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        unique case (w_op)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (w_a[MSB] != w_b[MSB]) && (w_diff[MSB] != w_a[MSB]);
            end
            OP_EQ:  w_res = DATA_WIDTH'(w_a == w_b);
            OP_GT:  w_res = DATA_WIDTH'(w_a > w_b);
            OP_MUL: w_res = w_prod;
            OP_NOT: w_res = ~w_a;
            OP_AND: w_res = w_a & w_b;
            OP_OR:  w_res = w_a | w_b;
            default: begin
                w_res = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= '0;
            r_zero <= 1'b1;
            r_ovf  <= 1'b0;
        end else begin
            r_out  <= w_res;
            r_zero <= (w_res == '0);
            r_ovf  <= w_ovf;
        end
    end

    assign bus.out_alu = r_out;
    assign bus.zero    = r_zero;
    assign bus.ovf     = r_ovf;
endmodule

// File: tb/tb_simple_alu.sv
// Self-checking bench for simple_alu: directed cases, then randomized
// back-to-back traffic against an arithmetic reference model.
module tb_simple_alu;
    localparam int unsigned DW = 32;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    logic [DW-1:0] prev_r;
    logic          prev_ov;
    logic          have_prev = 1'b0;

    simple_alu_if #(.DATA_WIDTH(DW), .OP_WIDTH(3)) bus ();

    simple_alu #(.DATA_WIDTH(DW), .OP_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: widen to 64-bit signed integers and apply the op rules directly.
    function automatic void model(input logic rs, input logic [2:0] op,
                                  input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  output logic [DW-1:0] r, output logic ov);
        longint sa, sb, full, ha, hb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ha = longint'($signed(a[15:0]));
        hb = longint'($signed(b[15:0]));
        r  = '0;
        ov = 1'b0;
        if (rs) return;
        case (op)
            3'd0: begin full = sa + sb; r = full[31:0]; ov = (full > MAXI) || (full < MINI); end
            3'd1: begin full = sa - sb; r = full[31:0]; ov = (full > MAXI) || (full < MINI); end
            3'd2: r = (a == b) ? 32'd1 : 32'd0;
            3'd3: r = (sa > sb) ? 32'd1 : 32'd0;
            3'd4: begin full = ha * hb; r = full[31:0]; end
            3'd5: r = ~a;
            3'd6: r = a & b;
            default: r = a | b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: confirm outputs still hold the last result, drive, then check new result.
    task automatic step(input string tag, input logic rs, input logic [2:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] er;
        logic          eov;
        @(negedge clk);
        if (have_prev) check({tag, ":hold"}, bus.out_alu, prev_r);
        rst     = rs;
        bus.op  = op;
        bus.in1 = a;
        bus.in2 = b;
        model(rs, op, a, b, er, eov);
        @(posedge clk);
        #1;
        check({tag, ":out"},  bus.out_alu, er);
        check({tag, ":zero"}, DW'(bus.zero), DW'(er == '0));
        check({tag, ":ovf"},  DW'(bus.ovf),  DW'(eov));
        prev_r    = er;
        prev_ov   = eov;
        have_prev = 1'b1;
    endtask

    task automatic expect_val(input string tag, input logic [DW-1:0] exp, input logic exp_ov);
        check({tag, ":spec"},    bus.out_alu, exp);
        check({tag, ":specovf"}, DW'(bus.ovf), DW'(exp_ov));
    endtask

    function automatic logic [DW-1:0] pick_operand();
        logic [DW-1:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'h0000_0001;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'h8000_0000;
            5: v = 32'h0000_8000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        rst     = 1'b1;
        bus.op  = '0;
        bus.in1 = '0;
        bus.in2 = '0;

        step("rst0", 1'b1, 3'($urandom), $urandom, $urandom);
        expect_val("rst0", 32'h0, 1'b0);
        check("rst0:zero1", DW'(bus.zero), 32'd1);
        step("rst1", 1'b1, 3'($urandom), $urandom, $urandom);

        step("add",   1'b0, 3'd0, 32'd5, 32'd8);            expect_val("add", 32'd13, 1'b0);
        step("sub",   1'b0, 3'd1, 32'd10, 32'd3);           expect_val("sub", 32'd7, 1'b0);
        step("addw",  1'b0, 3'd0, 32'h7FFF_FFFF, 32'd1);    expect_val("addw", 32'h8000_0000, 1'b1);
        step("subz",  1'b0, 3'd1, 32'd5, 32'd5);            expect_val("subz", 32'd0, 1'b0);
        check("subz:zero1", DW'(bus.zero), 32'd1);
        step("subw",  1'b0, 3'd1, 32'h8000_0000, 32'd1);    expect_val("subw", 32'h7FFF_FFFF, 1'b1);
        step("eq1",   1'b0, 3'd2, 32'd15, 32'd15);          expect_val("eq1", 32'd1, 1'b0);
        step("eq0",   1'b0, 3'd2, 32'd15, 32'd16);          expect_val("eq0", 32'd0, 1'b0);
        step("gt1",   1'b0, 3'd3, 32'd20, 32'd10);          expect_val("gt1", 32'd1, 1'b0);
        step("gts",   1'b0, 3'd3, 32'hFFFF_FFFF, 32'd1);    expect_val("gts", 32'd0, 1'b0);
        step("mul",   1'b0, 3'd4, 32'd4, 32'd8);            expect_val("mul", 32'd32, 1'b0);
        step("mulhi", 1'b0, 3'd4, 32'h1234_0004, 32'hABCD_0008); expect_val("mulhi", 32'd32, 1'b0);
        step("mulng", 1'b0, 3'd4, 32'hFFFF_FFFD, 32'd7);    expect_val("mulng", 32'hFFFF_FFEB, 1'b0);
        step("mulmx", 1'b0, 3'd4, 32'hFFFF_8000, 32'h0000_8000); expect_val("mulmx", 32'h4000_0000, 1'b0);
        step("not",   1'b0, 3'd5, 32'h0000_FFFF, 32'd0);    expect_val("not", 32'hFFFF_0000, 1'b0);
        step("and",   1'b0, 3'd6, 32'h0000_F0F0, 32'h0000_FF00); expect_val("and", 32'h0000_F000, 1'b0);
        step("or",    1'b0, 3'd7, 32'h0000_F0F0, 32'h0000_0F0F); expect_val("or", 32'h0000_FFFF, 1'b0);

        // Back-to-back randomized traffic with occasional mid-stream resets.
        for (int i = 0; i < 300; i++) begin
            step($sformatf("rnd%0d", i), ($urandom_range(0, 19) == 0),
                 3'($urandom), pick_operand(), pick_operand());
        end

        step("midrst", 1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1);
        expect_val("midrst", 32'h0, 1'b0);
        step("post",   1'b0, 3'd0, 32'd1, 32'd2);
        expect_val("post", 32'd3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
